// File: rtl/irq_timer_src.sv
// -----------------------------------------------------------------------------
// irq_timer_src
//   Machine-level interrupt source. It contains:
//     - a 64-bit free-running mtime counter advanced by a 16-bit prescaler
//     - a 64-bit mtimecmp register; the timer interrupt is registered (mtime >= mtimecmp)
//     - an external interrupt conditioner: a synchronizer, then edge or level capture
//   The exception vector goes to the CSR file: bit 7 = timer, bit 11 = external.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   sel         block select from the address decoder
//   address     byte offset; only [4:2] are decoded
//   reg_wr      write strobe, qualified by sel
//   reg_rd      read strobe, qualified by sel
//   wdata       write data (word accesses only)
//   ext_irq_in  asynchronous external interrupt line
//   rd_data     combinational read data, 0 when no read is in progress
//   excep       exception vector (bit 7 timer, bit 11 external)
//
// Register map
//   0x00 mtime_lo   0x04 mtime_hi   0x08 mtimecmp_lo   0x0C mtimecmp_hi
//   0x10 prescale[15:0]   0x14 ext_ctrl {mode, enable}   0x18 ext_pending (W1C)
//   0x1C reserved
//   Requirements: width >= 32 and SYNC_STAGES >= 2.
// -----------------------------------------------------------------------------
module irq_timer_src #(
  parameter int width       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [4:0]       address,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [width-1:0] wdata,
  input  logic             ext_irq_in,
  output logic [width-1:0] rd_data,
  output logic [width-1:0] excep
);

  typedef enum logic [2:0] {
    A_MTIME_LO  = 3'd0,
    A_MTIME_HI  = 3'd1,
    A_MTCMP_LO  = 3'd2,
    A_MTCMP_HI  = 3'd3,
    A_PRESCALE  = 3'd4,
    A_EXT_CTRL  = 3'd5,
    A_EXT_PEND  = 3'd6,
    A_RESERVED  = 3'd7
  } reg_addr_e;

  reg_addr_e   reg_addr;
  logic        wr_en, rd_en;
  logic [31:0] wdata_w;
  logic        unused_addr_bits;

  assign reg_addr         = reg_addr_e'(address[4:2]);
  assign wr_en            = sel & reg_wr;
  assign rd_en            = sel & reg_rd;
  assign wdata_w          = wdata[31:0];
  assign unused_addr_bits = ^address[1:0];

  // State
  logic [31:0]            mtime_lo_q, mtime_lo_d;
  logic [31:0]            mtime_hi_q, mtime_hi_d;
  logic [31:0]            mtcmp_lo_q, mtcmp_lo_d;
  logic [31:0]            mtcmp_hi_q, mtcmp_hi_d;
  logic [15:0]            prescale_q, prescale_d;
  logic [15:0]            presc_cnt_q, presc_cnt_d;
  logic                   timer_irq_q, timer_irq_d;
  logic [1:0]             ext_ctrl_q, ext_ctrl_d;     // [0] enable, [1] mode (1 = level)
  logic                   ext_pend_q, ext_pend_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_s_d_q;

  logic tick, ext_s, ext_rise, w1c;

  assign tick     = (presc_cnt_q == prescale_q);
  assign ext_s    = sync_q[SYNC_STAGES-1];
  assign ext_rise = ext_s & ~ext_s_d_q;
  assign w1c      = wr_en && (reg_addr == A_EXT_PEND) && wdata_w[0];

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    mtime_lo_d  = mtime_lo_q;
    mtime_hi_d  = mtime_hi_q;
    mtcmp_lo_d  = mtcmp_lo_q;
    mtcmp_hi_d  = mtcmp_hi_q;
    prescale_d  = prescale_q;
    ext_ctrl_d  = ext_ctrl_q;
    presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;

    // The high word uses the current low word to form the carry, in the same cycle.
    if (tick) begin
      mtime_lo_d = mtime_lo_q + 32'd1;
      if (mtime_lo_q == 32'hFFFF_FFFF) mtime_hi_d = mtime_hi_q + 32'd1;
    end

    // Bus writes come after the increment, so a write takes priority over a tick.
    if (wr_en) begin
      case (reg_addr)
        A_MTIME_LO: mtime_lo_d = wdata_w;
        A_MTIME_HI: mtime_hi_d = wdata_w;
        A_MTCMP_LO: mtcmp_lo_d = wdata_w;
        A_MTCMP_HI: mtcmp_hi_d = wdata_w;
        A_PRESCALE: begin
          prescale_d  = wdata_w[15:0];
          presc_cnt_d = 16'd0;
        end
        A_EXT_CTRL: ext_ctrl_d = wdata_w[1:0];
        default: ;
      endcase
    end

    timer_irq_d = ({mtime_hi_q, mtime_lo_q} >= {mtcmp_hi_q, mtcmp_lo_q});

    // In edge mode the set is applied last, so a new edge beats a coincident W1C.
    // In level mode the pending bit simply follows the synchronized line.
    if (ext_ctrl_q[1]) begin
      ext_pend_d = ext_s;
    end else begin
      ext_pend_d = ext_pend_q;
      if (w1c)      ext_pend_d = 1'b0;
      if (ext_rise) ext_pend_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_lo_q  <= '0;
      mtime_hi_q  <= '0;
      mtcmp_lo_q  <= 32'hFFFF_FFFF;
      mtcmp_hi_q  <= 32'hFFFF_FFFF;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      timer_irq_q <= 1'b0;
      ext_ctrl_q  <= '0;
      ext_pend_q  <= 1'b0;
      sync_q      <= '0;
      ext_s_d_q   <= 1'b0;
    end else begin
      mtime_lo_q  <= mtime_lo_d;
      mtime_hi_q  <= mtime_hi_d;
      mtcmp_lo_q  <= mtcmp_lo_d;
      mtcmp_hi_q  <= mtcmp_hi_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      timer_irq_q <= timer_irq_d;
      ext_ctrl_q  <= ext_ctrl_d;
      ext_pend_q  <= ext_pend_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
      ext_s_d_q   <= ext_s;
    end
  end

  // Read mux. The reset gate makes rd_data 0 while reset is held, even
  // though mtimecmp resets to all ones.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (rd_en && reset) begin
      case (reg_addr)
        A_MTIME_LO: rd_word = mtime_lo_q;
        A_MTIME_HI: rd_word = mtime_hi_q;
        A_MTCMP_LO: rd_word = mtcmp_lo_q;
        A_MTCMP_HI: rd_word = mtcmp_hi_q;
        A_PRESCALE: rd_word = {16'd0, prescale_q};
        A_EXT_CTRL: rd_word = {30'd0, ext_ctrl_q};
        A_EXT_PEND: rd_word = {31'd0, ext_pend_q};
        default:    rd_word = '0;
      endcase
    end
  end
  assign rd_data = width'(rd_word);

  always_comb begin
    excep     = '0;
    excep[7]  = timer_irq_q;
    excep[11] = ext_pend_q & ext_ctrl_q[0];
  end

endmodule

// File: tb/tb_irq_timer_src.sv
// -----------------------------------------------------------------------------
// tb_irq_timer_src
//   Self-checking bench for irq_timer_src. Each bus cycle pushes the expected
//   read data (and, optionally, the expected exception vector) onto a
//   scoreboard queue. Entries are popped and compared on the falling edge of
//   that same cycle. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_irq_timer_src;

  localparam int W = 32;
  localparam int S = 2;

  localparam logic [4:0] R_MT_LO = 5'h00, R_MT_HI = 5'h04, R_CMP_LO = 5'h08,
                         R_CMP_HI = 5'h0C, R_PRESC = 5'h10, R_CTRL = 5'h14,
                         R_PEND = 5'h18, R_RSVD = 5'h1C;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel, reg_wr, reg_rd, ext_irq_in;
  logic [4:0]   address;
  logic [W-1:0] wdata, rd_data, excep;

  irq_timer_src #(.width(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .address    (address),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .wdata      (wdata),
    .ext_irq_in (ext_irq_in),
    .rd_data    (rd_data),
    .excep      (excep)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          is_exc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle write; returns 1 time unit after the committing edge.
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; reg_wr = 1'b1; address = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; reg_wr = 1'b0;
  endtask

  // One-cycle read; compares rd_data and optionally excep during this cycle.
  task automatic bus_rd(input logic [4:0] a, input logic [31:0] exp_rd,
                        input bit chk_exc, input logic [31:0] exp_exc, input string tag);
    exp_t e;
    sb_q.push_back('{tag: tag, exp: exp_rd, is_exc: 1'b0});
    if (chk_exc) sb_q.push_back('{tag: {tag, "/excep"}, exp: exp_exc, is_exc: 1'b1});
    sel = 1'b1; reg_rd = 1'b1; address = a;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, e.is_exc ? excep : rd_data, e.exp);
    end
    @(posedge clk); #1;
    sel = 1'b0; reg_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sel = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    address = '0; wdata = '0; ext_irq_in = 1'b0;
    @(posedge clk); #1;

    // While reset is held, a read returns 0 even for the all-ones mtimecmp.
    bus_rd(R_CMP_LO, 32'h0, 1, 32'h0, "rst_held_rd");
    reset = 1'b1;

    // Reset values. mtime starts counting right away, so read it first.
    bus_rd(R_MT_LO,  32'h0,         1, 32'h0, "rst_mtime_lo");
    bus_rd(R_MT_HI,  32'h0,         1, 32'h0, "rst_mtime_hi");
    bus_rd(R_CMP_LO, 32'hFFFF_FFFF, 1, 32'h0, "rst_cmp_lo");
    bus_rd(R_CMP_HI, 32'hFFFF_FFFF, 1, 32'h0, "rst_cmp_hi");
    bus_rd(R_PRESC,  32'h0,         1, 32'h0, "rst_prescale");
    bus_rd(R_CTRL,   32'h0,         1, 32'h0, "rst_ext_ctrl");
    bus_rd(R_PEND,   32'h0,         1, 32'h0, "rst_ext_pend");
    bus_rd(R_RSVD,   32'h0,         1, 32'h0, "rst_reserved");

    // Timer compare with prescale 0. mtime_lo is written in c1, so mtime reads c-2 in cycle c.
    // mtimecmp becomes {0,10} in c3. mtime reaches 10 in c12, and excep[7] is set from c13.
    bus_wr(R_CMP_LO, 32'd10);          // c0
    bus_wr(R_MT_LO,  32'd0);           // c1
    bus_wr(R_CMP_HI, 32'd0);           // c2
    for (int c = 3; c <= 14; c++)
      bus_rd(R_MT_LO, 32'(c - 2), 1, (c >= 13) ? 32'h80 : 32'h0, $sformatf("tmr_c%0d", c));
    bus_wr(R_CMP_LO, 32'd100);         // the compare in this cycle still uses 10
    bus_rd(5'h0B, 32'd100, 1, 32'h80, "tmr_ack_d1");   // address[1:0] ignored
    bus_rd(R_CMP_LO, 32'd100, 1, 32'h0, "tmr_ack_d2");

    // Prescale 3. After the mtime_lo write in p1, ticks occur in p4, p8, ...
    // Cycle pc therefore reads (pc-1)/4, which gives 5 in p21.
    bus_wr(R_PRESC, 32'd3);            // p0
    bus_wr(R_MT_LO, 32'd0);            // p1
    for (int pc = 2; pc <= 21; pc++)
      bus_rd(R_MT_LO, 32'((pc - 1) / 4), 1, 32'h0, $sformatf("presc_p%0d", pc));
    bus_rd(R_PRESC, 32'd3, 0, 32'h0, "presc_readback");

    // Carry from the low word into the high word.
    bus_wr(R_PRESC, 32'd0);
    bus_wr(R_MT_HI, 32'd0);
    bus_wr(R_MT_LO, 32'hFFFF_FFFF);
    bus_rd(R_MT_LO, 32'hFFFF_FFFF, 0, 32'h0, "carry_lo_pre");
    bus_rd(R_MT_LO, 32'h0,         0, 32'h0, "carry_lo_post");
    bus_rd(R_MT_HI, 32'h1,         0, 32'h0, "carry_hi_post");

    // A write that coincides with a tick stores wdata.
    bus_wr(R_MT_LO, 32'h1234);
    bus_rd(R_MT_LO, 32'h1234, 0, 32'h0, "wr_beats_tick");
    bus_rd(R_MT_LO, 32'h1235, 0, 32'h0, "inc_after_wr");

    // 64-bit wrap from all ones to zero.
    bus_wr(R_MT_HI, 32'hFFFF_FFFF);
    bus_wr(R_MT_LO, 32'hFFFF_FFFF);
    bus_rd(R_MT_HI, 32'hFFFF_FFFF, 0, 32'h0, "wrap_hi_pre");
    bus_rd(R_MT_LO, 32'h0,         0, 32'h0, "wrap_lo_post");
    bus_rd(R_MT_HI, 32'h0,         0, 32'h0, "wrap_hi_post");

    // Park the compare value far away. Writes to the reserved offset are ignored.
    bus_wr(R_CMP_HI, 32'hFFFF_FFFF);
    bus_wr(R_RSVD, 32'hFFFF_FFFF);
    bus_rd(R_RSVD, 32'h0, 1, 32'h0, "reserved_wr");

    // Edge mode, enabled. A one-cycle pulse shows up S+1 cycles later.
    bus_wr(R_CTRL, 32'h1);
    ext_irq_in = 1'b1;
    bus_rd(R_PEND, 32'h0, 1, 32'h0, "edge_t0");
    ext_irq_in = 1'b0;
    for (int k = 1; k <= S; k++)
      bus_rd(R_PEND, 32'h0, 1, 32'h0, $sformatf("edge_t%0d", k));
    bus_rd(R_PEND, 32'h1, 1, 32'h800, "edge_set");
    bus_wr(R_PEND, 32'h2);                     // bit0 clear: not an acknowledge
    bus_rd(R_PEND, 32'h1, 1, 32'h800, "w1c_bit0_zero");
    bus_wr(R_PEND, 32'h1);
    bus_rd(R_PEND, 32'h0, 1, 32'h0, "w1c_clear");

    // A W1C in the cycle where the synchronized edge appears: the set wins.
    ext_irq_in = 1'b1;
    for (int k = 0; k < S; k++)
      bus_rd(R_PEND, 32'h0, 1, 32'h0, $sformatf("race_pre%0d", k));
    bus_wr(R_PEND, 32'h1);
    bus_rd(R_PEND, 32'h1, 1, 32'h800, "race_set_wins");
    bus_wr(R_PEND, 32'h1);                     // line held high but no new edge
    bus_rd(R_PEND, 32'h0, 1, 32'h0, "edge_no_level");
    ext_irq_in = 1'b0;
    for (int k = 0; k < S + 2; k++)
      bus_rd(R_RSVD, 32'h0, 1, 32'h0, $sformatf("settle%0d", k));

    // Level mode, disabled. Pending follows the line, but excep[11] stays masked.
    bus_wr(R_CTRL, 32'h2);
    ext_irq_in = 1'b1;
    for (int k = 0; k <= S; k++)
      bus_rd(R_PEND, 32'h0, 1, 32'h0, $sformatf("lvl_rise%0d", k));
    bus_rd(R_PEND, 32'h1, 1, 32'h0, "lvl_pend_masked");
    bus_wr(R_PEND, 32'h1);
    bus_rd(R_PEND, 32'h1, 1, 32'h0, "lvl_w1c_no_effect");
    bus_wr(R_CTRL, 32'h3);
    bus_rd(R_CTRL, 32'h3, 1, 32'h800, "lvl_enable");
    ext_irq_in = 1'b0;
    for (int k = 0; k <= S; k++)
      bus_rd(R_PEND, 32'h1, 1, 32'h800, $sformatf("lvl_fall%0d", k));
    bus_rd(R_PEND, 32'h0, 1, 32'h0, "lvl_cleared");

    // Switching from level to edge mode keeps the pending bit.
    ext_irq_in = 1'b1;
    for (int k = 0; k <= S; k++)
      bus_rd(R_PEND, 32'h0, 1, 32'h0, $sformatf("sw_rise%0d", k));
    bus_rd(R_PEND, 32'h1, 1, 32'h800, "sw_pend_level");
    bus_wr(R_CTRL, 32'h1);
    bus_rd(R_PEND, 32'h1, 1, 32'h800, "sw_pend_kept");
    ext_irq_in = 1'b0;

    // Reset asserted mid-run: state clears immediately.
    reset = 1'b0;
    bus_rd(R_CMP_HI, 32'h0, 1, 32'h0, "rst2_held");
    reset = 1'b1;
    bus_rd(R_CMP_HI, 32'hFFFF_FFFF, 1, 32'h0, "rst2_cmp_hi");
    bus_rd(R_PEND,   32'h0,         1, 32'h0, "rst2_pend");
    bus_rd(R_CTRL,   32'h0,         1, 32'h0, "rst2_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
